// File: rtl/stream_window_3.sv
// stream_window_3: raster pixel stream to registered 3x3 window using two line buffers.
// Optional STREAM_WINDOW_COORD_EN adds out_x/out_y window-centre coordinates.
module stream_window_3 #(
  parameter int PRECISION = 16,
  parameter int WIDTH = 640,
  parameter int HEIGHT = 480
) (
  input  logic clk,
  input  logic reset_n,
  input  logic in_valid,
  input  logic frame_start,
  input  logic signed [PRECISION-1:0] in_pixel,
  output logic signed [2:0][2:0][PRECISION-1:0] buffer_3,
  output logic out_valid
`ifdef STREAM_WINDOW_COORD_EN
  ,
  output logic [$clog2(WIDTH)-1:0] out_x,
  output logic [$clog2(HEIGHT)-1:0] out_y
`endif
);
  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);
  logic [XW-1:0] x_q, x_d, cx;
  logic [YW-1:0] y_q, y_d, cy;
  logic [PRECISION-1:0] lb0_q [WIDTH];
  logic [PRECISION-1:0] lb1_q [WIDTH];
  logic [PRECISION-1:0] old0, old1;
  logic [2:0][2:0][PRECISION-1:0] win_q, win_d;
  logic valid_q, valid_d;
  always_comb begin
    cx = frame_start ? '0 : x_q;
    cy = frame_start ? '0 : y_q;
    old0 = lb0_q[cx];
    old1 = lb1_q[cx];
    x_d = x_q;
    y_d = y_q;
    win_d = win_q;
    valid_d = in_valid && cx >= XW'(2) && cy >= YW'(2);
    if (in_valid) begin
      x_d = (cx == XW'(WIDTH-1)) ? '0 : cx + XW'(1);
      y_d = (cx != XW'(WIDTH-1)) ? cy : (cy == YW'(HEIGHT-1)) ? '0 : cy + YW'(1);
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
      win_d[0][2] = old1;
      win_d[1][2] = old0;
      win_d[2][2] = in_pixel;
    end
  end
  // line buffers are deliberately unreset; out_valid gating hides stale data
  always_ff @(posedge clk) begin
    if (in_valid) begin
      lb0_q[cx] <= in_pixel;
      lb1_q[cx] <= old0;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_q <= '0;
      y_q <= '0;
      win_q <= '0;
      valid_q <= 1'b0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
      win_q <= win_d;
      valid_q <= valid_d;
    end
  end
  assign buffer_3 = win_q;
  assign out_valid = valid_q;
`ifdef STREAM_WINDOW_COORD_EN
  logic [XW-1:0] ox_q;
  logic [YW-1:0] oy_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ox_q <= '0;
      oy_q <= '0;
    end else if (in_valid) begin
      ox_q <= cx - XW'(1);
      oy_q <= cy - YW'(1);
    end
  end
  assign out_x = ox_q;
  assign out_y = oy_q;
`endif
endmodule

// File: tb/tb_stream_window_3.sv
// tb_stream_window_3: table vectors, hand corner sequences and a randomized image-array reference model.
module tb_stream_window_3;
  localparam int P = 16, W = 4, H = 4;
  typedef logic [2:0][2:0][P-1:0] win_t;
  typedef struct {
    logic [P-1:0] px;
    logic fs;
    logic ev;
    win_t ew;
  } vec_t;
  logic clk = 0, reset_n = 0, in_valid = 0, frame_start = 0;
  logic signed [P-1:0] in_pixel = '0;
  logic signed [2:0][2:0][P-1:0] buffer_3;
  logic out_valid;
`ifdef STREAM_WINDOW_COORD_EN
  logic [1:0] out_x, out_y;
`endif
  int total = 0, passed = 0, strobes = 0;
  logic [P-1:0] img [H][W];
  int mx = 0, my = 0;
  vec_t vec [16];
  always #5 clk = ~clk;
  stream_window_3 #(.PRECISION(P), .WIDTH(W), .HEIGHT(H)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .frame_start(frame_start),
    .in_pixel(in_pixel), .buffer_3(buffer_3), .out_valid(out_valid)
`ifdef STREAM_WINDOW_COORD_EN
    , .out_x(out_x), .out_y(out_y)
`endif
  );
  task automatic chk(input string n, input logic [159:0] act, input logic [159:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", n, act, exp);
  endtask
  // drive one accepted pixel, predict from the stored image, check 1 clk later
  task automatic send(input logic [P-1:0] p, input logic fs);
    logic ev;
    win_t ew;
    int ex, ey;
    @(negedge clk);
    in_valid = 1; frame_start = fs; in_pixel = p;
    if (fs) begin mx = 0; my = 0; end
    img[my][mx] = p;
    ev = mx >= 2 && my >= 2;
    ew = '0;
    if (ev) for (int r = 0; r < 3; r++) for (int c = 0; c < 3; c++) ew[r][c] = img[my-2+r][mx-2+c];
    ex = mx - 1; ey = my - 1;
    mx = mx + 1;
    if (mx == W) begin mx = 0; my = (my == H - 1) ? 0 : my + 1; end
    @(posedge clk); #1;
    chk("out_valid", {159'd0, out_valid}, {159'd0, ev});
    if (ev) begin
      strobes++;
      chk("window", {buffer_3}, ew);
`ifdef STREAM_WINDOW_COORD_EN
      chk("coord", {out_y, out_x}, {ey[1:0], ex[1:0]});
`endif
    end
    in_valid = 0; frame_start = 0;
  endtask
  task automatic idle();
    @(negedge clk);
    in_valid = 0; frame_start = 1'($urandom_range(0, 1)); in_pixel = P'($urandom);
    @(posedge clk); #1;
    chk("bubble_valid", {159'd0, out_valid}, 160'd0);
    frame_start = 0;
  endtask
  task automatic grid_frame(input int max_gap, input logic fs0);
    for (int i = 0; i < W * H; i++) begin
      for (int g = $urandom_range(0, max_gap); g > 0; g--) idle();
      send(P'(10 * (i / W) + i % W), fs0 && i == 0);
    end
  endtask
  initial begin
    for (int i = 0; i < 16; i++) begin
      vec[i].px = P'(10 * (i / 4) + i % 4);
      vec[i].fs = i == 0;
      vec[i].ev = (i % 4) >= 2 && (i / 4) >= 2;
      vec[i].ew = '0;
      if (vec[i].ev)
        for (int r = 0; r < 3; r++) for (int c = 0; c < 3; c++)
          vec[i].ew[r][c] = P'(10 * (i / 4 - 2 + r) + (i % 4 - 2 + c));
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); in_valid = 1; frame_start = i == 0; in_pixel = P'(100 + i);
      @(posedge clk); #1;
      chk("rst_hold_valid", {159'd0, out_valid}, 160'd0);
      chk("rst_hold_win", {buffer_3}, 160'd0);
    end
    in_valid = 0; frame_start = 0;
    @(negedge clk); reset_n = 1;
    strobes = 0;
    for (int i = 0; i < 16; i++) begin
      send(vec[i].px, vec[i].fs);
      chk("tbl_valid", {159'd0, out_valid}, {159'd0, vec[i].ev});
      if (vec[i].ev) chk("tbl_win", {buffer_3}, vec[i].ew);
      if (i == 10) chk("first_win", {buffer_3}, {16'd22, 16'd21, 16'd20, 16'd12, 16'd11, 16'd10, 16'd2, 16'd1, 16'd0});
      if (i == 14) chk("wrap_win32", {buffer_3}, {16'd32, 16'd31, 16'd30, 16'd22, 16'd21, 16'd20, 16'd12, 16'd11, 16'd10});
      if (i == 15) chk("wrap_win33", {buffer_3}, {16'd33, 16'd32, 16'd31, 16'd23, 16'd22, 16'd21, 16'd13, 16'd12, 16'd11});
    end
    chk("strobes_frame", 160'(strobes), 160'd4);
    strobes = 0;
    grid_frame(5, 1'b1);
    chk("strobes_bubbles", 160'(strobes), 160'd4);
    strobes = 0;
    for (int i = 0; i < 5; i++) send(P'(10 * (i / W) + i % W), i == 0);
    chk("strobes_prefix", 160'(strobes), 160'd0);
    grid_frame(0, 1'b1);
    chk("strobes_restart", 160'(strobes), 160'd4);
    strobes = 0;
    for (int i = 0; i < 11; i++) send(P'(10 * (i / W) + i % W), i == 0);
    chk("pre_reset_valid", {159'd0, out_valid}, 160'd1);
    #2 reset_n = 0;
    #1;
    chk("async_rst_valid", {159'd0, out_valid}, 160'd0);
    chk("async_rst_win", {buffer_3}, 160'd0);
    @(negedge clk); reset_n = 1; mx = 0; my = 0;
    strobes = 0;
    grid_frame(2, 1'b0);
    chk("strobes_after_rst", 160'(strobes), 160'd4);
    for (int i = 0; i < 3 * W * H; i++) begin
      for (int g = $urandom_range(0, 3); g > 0; g--) idle();
      send(P'($urandom), $urandom_range(0, 39) == 0);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/stream_window_3.md
Name: stream_window_3

Overview:
Upstream feeder for the 3x3 stream convolution kernel. Accepts a raster-order pixel stream, one pixel per valid cycle, and holds two WIDTH-deep line buffers. Drives a registered 3x3 neighbourhood window with a valid strobe that goes high only when all nine taps hold real pixels of the current frame. The window output connects directly to the kernel's buffer_3 input.

Parameters:
PRECISION, 16, signed pixel/tap width in bits
WIDTH, 640, active pixels per line (>= 3)
HEIGHT, 480, active lines per frame (>= 3)

Ports:
clk  in  1  system clock, all state on rising edge
reset_n  in  1  asynchronous, active-low reset
in_valid  in  1  in_pixel/frame_start qualify this cycle
frame_start  in  1  with in_valid: this pixel is (0,0) of a new frame
in_pixel  in  PRECISION signed  incoming pixel
buffer_3  out  [2:0][2:0] x PRECISION signed  window; [r][c], r=0 oldest row, c=0 oldest (leftmost) column
out_valid  out  1  one-cycle strobe: buffer_3 holds a complete window

Behaviour:
- Reset (async assert, sync release): all buffer_3 taps 0, out_valid 0, col counter x=0, row counter y=0. Line-buffer RAM is not reset; stale contents are never exposed because out_valid is gated.
- Coordinates of the accepted pixel: (0,0) if frame_start, else the current (x,y).
- Counter advance per accepted pixel: x+1; at x=WIDTH-1, x->0 and y+1; at (WIDTH-1,HEIGHT-1), both ->0.
- Line buffers lb0 (row y-1) and lb1 (row y-2), indexed by x.
- Per accepted pixel p at column x:
  - Read lb0[x] and lb1[x] (old values).
  - Write lb0[x] <= p and lb1[x] <= old lb0[x]. Read-before-write at the same address.
- Window shift, registered:
  - buffer_3[r][0] <= buffer_3[r][1]
  - buffer_3[r][1] <= buffer_3[r][2]
  - buffer_3[0][2] <= old lb1[x], buffer_3[1][2] <= old lb0[x], buffer_3[2][2] <= p
- out_valid <= 1 on the cycle after an accepted pixel with x>=2 and y>=2; otherwise 0.
- Latency: exactly 1 clk from an accepted pixel to its window. Window centre is (x-1,y-1).
- in_valid=0: window, counters and line buffers hold; out_valid 0 next cycle. Bubbles of any length are legal.
- Line wrap: columns 0/1 carry the previous line's tail after x wraps; suppressed because x<2.
- frame_start mid-frame: counters restart at (0,0) with that pixel. No windows appear until (2,2) of the new frame. frame_start without in_valid is ignored.
- No backpressure; the downstream consumer always accepts.
- No border padding. Per frame, exactly (WIDTH-2)*(HEIGHT-2) out_valid strobes.

Optional Feature:
STREAM_WINDOW_COORD_EN:
- Defined: adds outputs out_x [$clog2(WIDTH)-1:0] and out_y [$clog2(HEIGHT)-1:0], registered alongside out_valid. They give the window centre (x-1,y-1) of the producing pixel and reset to 0.
- Undefined: no such ports and no extra registers. All other behaviour is identical.

Test Plan:
(WIDTH=4, HEIGHT=4, PRECISION=16, pixel value = 10*y+x)
- Reset: hold reset_n=0 while driving pixels -> out_valid=0 and all buffer_3=0. Assert reset_n=0 mid-frame -> outputs return to 0 asynchronously.
- Continuous frame with frame_start on pixel 0 -> first out_valid 1 clk after pixel 22 is accepted. Window rows {0,1,2},{10,11,12},{20,21,22}. Exactly 4 strobes per frame.
- Same frame with random 0-5 cycle in_valid bubbles -> identical 4 windows in order. out_valid never high during a bubble.
- Row wrap: pixels 30 and 31 -> no strobe. Pixel 32 -> window {10,11,12},{20,21,22},{30,31,32}. Pixel 33 -> window {11,12,13},{21,22,23},{31,32,33}.
- frame_start asserted on the 6th pixel, then a full frame -> no strobe until new-frame pixel 22. Total strobes for the new frame = 4.
- With STREAM_WINDOW_COORD_EN: the 4 strobes of a frame report (out_x,out_y) = (1,1),(2,1),(1,2),(2,2).
